// File: rtl/ssd1306_spi_master.sv
// Byte-wide SPI mode-0 transmitter for an SSD1306 OLED controller.
// Drives CS/SCK/MOSI/DC for one byte per Start_i, with a CS-high gap before Done_o.
module ssd1306_spi_master #(
   parameter int CLOCK_HZ = 25_175_000,
   parameter int SPI_HZ   = 6_293_750
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Start_i,
   input  logic [7:0] Data_i,
   input  logic       DC_i,
   output logic       Busy_o,
   output logic       Done_o,
   output logic       CS_o,
   output logic       SCK_o,
   output logic       MOSI_o,
   output logic       DC_o
);

   localparam int HALF_RAW = CLOCK_HZ / (2 * SPI_HZ);
   localparam int HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
   localparam int TW       = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [TW-1:0] TMAX = TW'(HALF - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SHIFT = 3'd2,
      HOLD  = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t          state_r, state_s;
   logic [TW-1:0]   timer_r, timer_s;
   logic [2:0]      bit_r, bit_s;
   logic [6:0]      shreg_r, shreg_s;
   logic            cs_r, cs_s;
   logic            sck_r, sck_s;
   logic            mosi_r, mosi_s;
   logic            dc_r, dc_s;
   logic            busy_r, busy_s;
   logic            done_r, done_s;
   logic            half_end_s;

   // State, counters and every output are registered here
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_r <= IDLE;
         timer_r <= '0;
         bit_r   <= 3'd0;
         shreg_r <= 7'd0;
         cs_r    <= 1'b1;
         sck_r   <= 1'b0;
         mosi_r  <= 1'b0;
         dc_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         timer_r <= timer_s;
         bit_r   <= bit_s;
         shreg_r <= shreg_s;
         cs_r    <= cs_s;
         sck_r   <= sck_s;
         mosi_r  <= mosi_s;
         dc_r    <= dc_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   // Next-state and next-output decode; each phase lasts HALF clocks
   always_comb begin
      state_s    = state_r;
      timer_s    = timer_r;
      bit_s      = bit_r;
      shreg_s    = shreg_r;
      cs_s       = cs_r;
      sck_s      = sck_r;
      mosi_s     = mosi_r;
      dc_s       = dc_r;
      busy_s     = busy_r;
      done_s     = 1'b0;
      half_end_s = (timer_r == TMAX);

      case (state_r)
         IDLE: begin
            timer_s = '0;
            bit_s   = 3'd0;
            cs_s    = 1'b1;
            sck_s   = 1'b0;
            mosi_s  = 1'b0;
            busy_s  = 1'b0;
            if (Start_i) begin
               state_s = SETUP;
               shreg_s = Data_i[6:0];
               mosi_s  = Data_i[7];
               dc_s    = DC_i;
               cs_s    = 1'b0;
               busy_s  = 1'b1;
            end else begin
               state_s = IDLE;
            end
         end

         SETUP: begin
            if (half_end_s) begin
               timer_s = '0;
               sck_s   = 1'b1;
               state_s = SHIFT;
            end else begin
               timer_s = timer_r + TW'(1);
            end
         end

         SHIFT: begin
            if (half_end_s) begin
               timer_s = '0;
               if (sck_r) begin
                  // Falling edge: advance MOSI, or finish after the eighth bit
                  sck_s = 1'b0;
                  if (bit_r == 3'd7) begin
                     bit_s   = 3'd0;
                     mosi_s  = 1'b0;
                     state_s = HOLD;
                  end else begin
                     bit_s   = bit_r + 3'd1;
                     mosi_s  = shreg_r[6];
                     shreg_s = {shreg_r[5:0], 1'b0};
                  end
               end else begin
                  sck_s = 1'b1;
               end
            end else begin
               timer_s = timer_r + TW'(1);
            end
         end

         HOLD: begin
            if (half_end_s) begin
               timer_s = '0;
               cs_s    = 1'b1;
               state_s = GAP;
            end else begin
               timer_s = timer_r + TW'(1);
            end
         end

         GAP: begin
            if (half_end_s) begin
               timer_s = '0;
               done_s  = 1'b1;
               busy_s  = 1'b0;
               state_s = IDLE;
            end else begin
               timer_s = timer_r + TW'(1);
            end
         end

         default: begin
            state_s = IDLE;
            timer_s = '0;
            bit_s   = 3'd0;
            cs_s    = 1'b1;
            sck_s   = 1'b0;
            mosi_s  = 1'b0;
            busy_s  = 1'b0;
         end
      endcase
   end

   assign Busy_o = busy_r;
   assign Done_o = done_r;
   assign CS_o   = cs_r;
   assign SCK_o  = sck_r;
   assign MOSI_o = mosi_r;
   assign DC_o   = dc_r;

endmodule

// File: tb/tb_ssd1306_spi_master.sv
// Directed bench for ssd1306_spi_master: default HALF=2 instance plus a HALF=1 instance.
module tb_ssd1306_spi_master;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       start = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       dcin  = 1'b0;
   logic       sel   = 1'b0;

   logic s1, s2;
   logic b1, d1, c1, k1, m1, o1;
   logic b2, d2, c2, k2, m2, o2;
   logic w_busy, w_done, w_cs, w_sck, w_mosi, w_dc;

   int passed = 0;
   int total  = 0;

   int         n_rise, first_rise, last_rise, cs_hi_at, cs_lo2, done_at, done_cnt, viol, busy_done;
   logic [15:0] rx;
   logic        dc_r1, dc_r9, dc_last;
   int          ign_at = -1;
   logic [7:0]  ign_data = 8'h00;
   logic        ign_dc = 1'b0;
   logic        b2b_pend = 1'b0;
   logic [7:0]  b2b_data = 8'h00;
   logic        b2b_dc = 1'b0;

   assign s1 = start & ~sel;
   assign s2 = start & sel;

   ssd1306_spi_master dut1 (
      .Clock(Clock), .Reset(Reset), .Start_i(s1), .Data_i(data), .DC_i(dcin),
      .Busy_o(b1), .Done_o(d1), .CS_o(c1), .SCK_o(k1), .MOSI_o(m1), .DC_o(o1)
   );

   ssd1306_spi_master #(.CLOCK_HZ(10), .SPI_HZ(100)) dut2 (
      .Clock(Clock), .Reset(Reset), .Start_i(s2), .Data_i(data), .DC_i(dcin),
      .Busy_o(b2), .Done_o(d2), .CS_o(c2), .SCK_o(k2), .MOSI_o(m2), .DC_o(o2)
   );

   assign w_busy = sel ? b2 : b1;
   assign w_done = sel ? d2 : d1;
   assign w_cs   = sel ? c2 : c1;
   assign w_sck  = sel ? k2 : k1;
   assign w_mosi = sel ? m2 : m1;
   assign w_dc   = sel ? o2 : o1;

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Observe cycles 2..ncyc after acceptance, decoding the SPI line and checking bus rules
   task automatic watch(input int ncyc);
      logic p_sck, p_mosi, p_cs, clr_next;
      n_rise = 0; rx = 16'h0000; first_rise = -1; last_rise = -1; cs_hi_at = -1;
      cs_lo2 = -1; done_at = -1; done_cnt = 0; viol = 0; busy_done = 0;
      dc_r1 = 1'b0; dc_r9 = 1'b0; dc_last = 1'b0; clr_next = 1'b0;
      p_sck = w_sck; p_mosi = w_mosi; p_cs = w_cs;
      for (int i = 2; i <= ncyc; i++) begin
         tick();
         if (clr_next) begin
            start = 1'b0;
            clr_next = 1'b0;
         end
         if (i == ign_at) begin
            start = 1'b1; data = ign_data; dcin = ign_dc;
         end else if (i == ign_at + 1) begin
            start = 1'b0;
         end
         if (w_sck && !p_sck) begin
            n_rise = n_rise + 1;
            rx = {rx[14:0], w_mosi};
            if (w_mosi !== p_mosi) viol = viol + 1;
            if (first_rise < 0) first_rise = i;
            last_rise = i;
            if (n_rise == 1) dc_r1 = w_dc;
            if (n_rise == 9) dc_r9 = w_dc;
            dc_last = w_dc;
         end
         if (w_cs && (w_sck || w_mosi)) viol = viol + 1;
         if (w_cs && !p_cs && cs_hi_at < 0) cs_hi_at = i;
         if (!w_cs && p_cs && cs_lo2 < 0) cs_lo2 = i;
         if (w_done) begin
            done_cnt = done_cnt + 1;
            if (done_at < 0) done_at = i;
            if (w_busy) busy_done = busy_done + 1;
            if (b2b_pend) begin
               start = 1'b1; data = b2b_data; dcin = b2b_dc;
               b2b_pend = 1'b0; clr_next = 1'b1;
            end
         end
         p_sck = w_sck; p_mosi = w_mosi; p_cs = w_cs;
      end
   endtask

   initial begin
      // Reset applies with no clock edge
      #1 Reset = 1'b1;
      #2;
      chk("rst_cs", int'(c1), 1);
      chk("rst_sck", int'(k1), 0);
      chk("rst_mosi", int'(m1), 0);
      chk("rst_dc", int'(o1), 0);
      chk("rst_busy", int'(b1), 0);
      chk("rst_done", int'(d1), 0);
      tick(); tick();
      Reset = 1'b0;
      tick();
      chk("idle_cs", int'(c1), 1);
      chk("idle_busy", int'(b1), 0);

      // A5 command byte
      data = 8'hA5; dcin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("a5_cs_t1", int'(w_cs), 0);
      chk("a5_busy_t1", int'(w_busy), 1);
      chk("a5_mosi_t1", int'(w_mosi), 1);
      chk("a5_sck_t1", int'(w_sck), 0);
      chk("a5_dc_t1", int'(w_dc), 0);
      watch(45);
      chk("a5_byte", int'(rx[7:0]), 8'hA5);
      chk("a5_rises", n_rise, 8);
      chk("a5_first_rise", first_rise, 3);
      chk("a5_last_rise", last_rise, 31);
      chk("a5_cs_high_at", cs_hi_at, 35);
      chk("a5_done_at", done_at, 37);
      chk("a5_done_cnt", done_cnt, 1);
      chk("a5_busy_in_done", busy_done, 0);
      chk("a5_dc_rise", int'(dc_r1), 0);
      chk("a5_bus_rules", viol, 0);

      // FF data byte then 00 command byte started in the Done_o cycle
      data = 8'hFF; dcin = 1'b1; start = 1'b1;
      b2b_pend = 1'b1; b2b_data = 8'h00; b2b_dc = 1'b0;
      tick();
      start = 1'b0;
      chk("b2b_dc_t1", int'(w_dc), 1);
      watch(80);
      chk("b2b_bytes", int'(rx), 16'hFF00);
      chk("b2b_rises", n_rise, 16);
      chk("b2b_dc_first", int'(dc_r1), 1);
      chk("b2b_dc_second", int'(dc_r9), 0);
      chk("b2b_cs_high_at", cs_hi_at, 35);
      chk("b2b_cs_low_again", cs_lo2, 38);
      chk("b2b_done_at", done_at, 37);
      chk("b2b_done_cnt", done_cnt, 2);
      chk("b2b_bus_rules", viol, 0);

      // C3 with a stray Start_i/Data_i/DC_i change at T+10
      data = 8'hC3; dcin = 1'b1; start = 1'b1;
      ign_at = 10; ign_data = 8'h12; ign_dc = 1'b0;
      tick();
      start = 1'b0;
      watch(45);
      ign_at = -1;
      chk("ign_byte", int'(rx[7:0]), 8'hC3);
      chk("ign_rises", n_rise, 8);
      chk("ign_done_cnt", done_cnt, 1);
      chk("ign_done_at", done_at, 37);
      chk("ign_dc_last", int'(dc_last), 1);
      chk("ign_bus_rules", viol, 0);

      // Reset in the middle of a byte, then 3C started in the release cycle
      data = 8'h96; dcin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      watch(15);
      chk("abort_no_done_before", done_cnt, 0);
      #2 Reset = 1'b1;
      #1;
      chk("abort_cs", int'(c1), 1);
      chk("abort_sck", int'(k1), 0);
      chk("abort_busy", int'(b1), 0);
      chk("abort_mosi", int'(m1), 0);
      chk("abort_dc", int'(o1), 0);
      tick();
      chk("abort_done", int'(d1), 0);
      Reset = 1'b0; data = 8'h3C; dcin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("fresh_cs_t1", int'(c1), 0);
      chk("fresh_mosi_t1", int'(m1), 0);
      chk("fresh_dc_t1", int'(o1), 1);
      watch(45);
      chk("fresh_byte", int'(rx[7:0]), 8'h3C);
      chk("fresh_rises", n_rise, 8);
      chk("fresh_first_rise", first_rise, 3);
      chk("fresh_cs_high_at", cs_hi_at, 35);
      chk("fresh_done_at", done_at, 37);
      chk("fresh_done_cnt", done_cnt, 1);
      chk("fresh_bus_rules", viol, 0);
      tick(); tick(); tick();
      chk("idle_dc_kept", int'(o1), 1);
      chk("idle_cs_after", int'(c1), 1);

      // HALF=1 instance, 81 command byte
      sel = 1'b1;
      data = 8'h81; dcin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("h1_cs_t1", int'(w_cs), 0);
      chk("h1_mosi_t1", int'(w_mosi), 1);
      watch(25);
      chk("h1_byte", int'(rx[7:0]), 8'h81);
      chk("h1_rises", n_rise, 8);
      chk("h1_first_rise", first_rise, 2);
      chk("h1_last_rise", last_rise, 16);
      chk("h1_cs_high_at", cs_hi_at, 18);
      chk("h1_done_at", done_at, 19);
      chk("h1_done_cnt", done_cnt, 1);
      chk("h1_bus_rules", viol, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
